// File: rtl/imem_loader.sv
// Boot loader for the instruction memory: takes a byte stream (16-bit word count,
// little-endian instructions, XOR checksum), writes the words and holds fetch until done.
module imem_loader #(
   parameter int          DEPTH_WORDS = 256,
   parameter logic [63:0] BASE_ADDR   = 64'd0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_req,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        imem_we,
   output logic [63:0] imem_addr,
   output logic [31:0] imem_wdata,
   output logic        core_hold,
   output logic        busy,
   output logic        done,
   output logic        err
);

   typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CSUM, DONE, ERR} state_t;

   localparam logic [16:0] DEPTH = 17'(DEPTH_WORDS);

   state_t      state, nxt;
   logic [15:0] idx, cnt;
   logic [1:0]  lane;
   logic [7:0]  acc;
   logic [31:0] asm_q, asm_nxt;
   logic        accept;
   logic [16:0] hdr_n;
   logic [15:0] idx_inc;
   logic        restart;

   assign accept  = byte_valid && byte_ready;
   assign hdr_n   = {1'b0, byte_data, cnt[7:0]};
   assign idx_inc = idx + 16'd1;
   assign restart = load_req && (state == IDLE || state == DONE || state == ERR);

   // Assembly register with the incoming byte dropped into the current lane.
   always_comb begin
      asm_nxt = asm_q;
      asm_nxt[8*lane +: 8] = byte_data;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:  if (load_req) nxt = HDR0;
         HDR0:  if (accept) nxt = HDR1;
         HDR1:  if (accept) begin
                   if (hdr_n > DEPTH)       nxt = ERR;
                   else if (hdr_n == 17'd0) nxt = CSUM;
                   else                     nxt = DATA;
                end
         DATA:  if (accept && lane == 2'd3) nxt = WRITE;
         WRITE: nxt = (idx_inc == cnt) ? CSUM : DATA;
         CSUM:  if (accept) nxt = (byte_data == acc) ? DONE : ERR;
         DONE:  if (load_req) nxt = HDR0;
         ERR:   if (load_req) nxt = HDR0;
         default: nxt = IDLE;
      endcase
   end

   // All handshake/status outputs are decoded from the next state so they are
   // registered and line up with the state they describe.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         byte_ready <= 1'b0;
         imem_we    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         core_hold  <= 1'b1;
         imem_addr  <= BASE_ADDR;
         imem_wdata <= 32'd0;
         idx        <= 16'd0;
         cnt        <= 16'd0;
         lane       <= 2'd0;
         acc        <= 8'd0;
         asm_q      <= 32'd0;
      end else begin
         state      <= nxt;
         byte_ready <= (nxt == HDR0) || (nxt == HDR1) || (nxt == DATA) || (nxt == CSUM);
         busy       <= (nxt == HDR0) || (nxt == HDR1) || (nxt == DATA) ||
                       (nxt == WRITE) || (nxt == CSUM);
         done       <= (nxt == DONE);
         err        <= (nxt == ERR);
         core_hold  <= (nxt != DONE);
         imem_we    <= (nxt == WRITE);

         if (restart) begin
            idx  <= 16'd0;
            cnt  <= 16'd0;
            lane <= 2'd0;
            acc  <= 8'd0;
         end

         // The checksum byte itself is compared, not folded in.
         if (accept && state != CSUM)
            acc <= acc ^ byte_data;

         case (state)
            HDR0: if (accept) cnt[7:0]  <= byte_data;
            HDR1: if (accept) cnt[15:8] <= byte_data;
            DATA: if (accept) begin
                     asm_q <= asm_nxt;
                     lane  <= lane + 2'd1;
                     if (lane == 2'd3) begin
                        imem_wdata <= asm_nxt;
                        imem_addr  <= BASE_ADDR + 64'({idx, 2'b00});
                     end
                  end
            WRITE: idx <= idx_inc;
            default: ;
         endcase
      end
   end

endmodule
